// File: rtl/video_pkg.sv
// Shared types for the raster timing generator: pixel modes,
// 24-bit colour and the colour-bar table.
package video_pkg;

   typedef enum logic [1:0] {
      VM_STREAM = 2'd0,
      VM_BARS   = 2'd1,
      VM_GRAD   = 2'd2,
      VM_CHECK  = 2'd3
   } vmode_e;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb24;

   localparam rgb24 RGB_BLACK = 24'h000000;
   localparam rgb24 RGB_WHITE = 24'hFFFFFF;
   localparam int   BAR_NUM   = 8;

   // Bar order left to right; indices past the last bar are black.
   function automatic rgb24 bar_colour(input logic [3:0] idx);
      case (idx)
         4'd0:    bar_colour = rgb24'(24'hFFFFFF);
         4'd1:    bar_colour = rgb24'(24'hFFFF00);
         4'd2:    bar_colour = rgb24'(24'h00FFFF);
         4'd3:    bar_colour = rgb24'(24'h00FF00);
         4'd4:    bar_colour = rgb24'(24'hFF00FF);
         4'd5:    bar_colour = rgb24'(24'hFF0000);
         4'd6:    bar_colour = rgb24'(24'h0000FF);
         default: bar_colour = RGB_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/vtg_pattern.sv
// Internal test-pattern source: colour bars, gradient, checker.
// Bars are tracked with a per-line sub-counter instead of a divider.
module vtg_pattern
   import video_pkg::*;
#(
   parameter int H_RES = 640
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       line_end,
   input  logic [7:0] x8,
   input  logic [7:0] y8,
   input  logic [7:0] frame_cnt,
   input  logic       chk_bit,
   input  vmode_e     mode,
   output rgb24       pix
);

   localparam int BW = (H_RES / BAR_NUM > 0) ? H_RES / BAR_NUM : 1;

   logic [15:0] bar_px;
   logic [3:0]  bar_idx;

   // Bar position follows h: cleared at line end, saturates past the last bar.
   always_ff @(posedge clk) begin
      if (rst || !run || line_end) begin
         bar_px  <= '0;
         bar_idx <= '0;
      end else if (bar_idx < 4'(BAR_NUM)) begin
         if (bar_px == 16'(BW - 1)) begin
            bar_px  <= '0;
            bar_idx <= bar_idx + 4'd1;
         end else begin
            bar_px <= bar_px + 16'd1;
         end
      end
   end

   // Pattern colour for the current raster position.
   always_comb begin
      pix = RGB_BLACK;
      case (mode)
         VM_BARS:  pix = bar_colour(bar_idx);
         VM_GRAD:  pix = {x8, y8, frame_cnt};
         VM_CHECK: pix = chk_bit ? RGB_WHITE : RGB_BLACK;
         default:  pix = RGB_BLACK;
      endcase
   end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with stream or pattern pixels.
// VTG_PATTERN_EN builds the internal patterns; without it mode is ignored.
module video_timing_gen
   import video_pkg::*;
#(
   parameter int H_RES    = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_RES    = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CNT_W    = 12,
   parameter int CHK_LOG2 = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             s_valid,
   input  logic [23:0]      s_data,
   output logic             s_ready,
   output logic             de,
   output logic             hs,
   output logic             vs,
   output logic [7:0]       r,
   output logic [7:0]       g,
   output logic [7:0]       b,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             sof,
   output logic             sol,
   output logic             underflow
);

   localparam int H_TOT  = H_RES + H_FP + H_SYNC + H_BP;
   localparam int V_TOT  = V_RES + V_FP + V_SYNC + V_BP;
   localparam int HS_BEG = H_RES + H_FP;
   localparam int HS_END = HS_BEG + H_SYNC;
   localparam int VS_BEG = V_RES + V_FP;
   localparam int VS_END = VS_BEG + V_SYNC;

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             h_last;
   logic             v_last;
   logic             origin;
   logic             active;
   logic             hs_on;
   logic             vs_on;
   vmode_e           mode_eff;
   rgb24             pix_d;
   logic             uf_d;

   assign h_last = (h_cnt == CNT_W'(H_TOT - 1));
   assign v_last = (v_cnt == CNT_W'(V_TOT - 1));
   assign origin = (h_cnt == '0) && (v_cnt == '0);
   assign active = (h_cnt < CNT_W'(H_RES)) && (v_cnt < CNT_W'(V_RES));
   assign hs_on  = (h_cnt >= CNT_W'(HS_BEG)) && (h_cnt < CNT_W'(HS_END));
   assign vs_on  = (v_cnt >= CNT_W'(VS_BEG)) && (v_cnt < CNT_W'(VS_END));

`ifdef VTG_PATTERN_EN
   vmode_e     mode_q;
   logic [7:0] frame_cnt;
   logic [7:0] frame_nxt;
   rgb24       pat_pix;

   // The mode seen at the frame origin applies to that whole frame.
   assign mode_eff  = origin ? vmode_e'(mode) : mode_q;
   assign frame_nxt = origin ? frame_cnt + 8'd1 : frame_cnt;

   // Latch mode and advance the frame number once per frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q    <= VM_STREAM;
         frame_cnt <= '0;
      end else if (en && origin) begin
         mode_q    <= mode_eff;
         frame_cnt <= frame_nxt;
      end
   end

   vtg_pattern #(
      .H_RES (H_RES)
   ) u_pattern (
      .clk       (clk),
      .rst       (rst),
      .run       (en),
      .line_end  (h_last),
      .x8        (h_cnt[7:0]),
      .y8        (v_cnt[7:0]),
      .frame_cnt (frame_nxt),
      .chk_bit   (h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]),
      .mode      (mode_eff),
      .pix       (pat_pix)
   );
`else
   logic unused_mode;

   assign unused_mode = ^mode;
   assign mode_eff    = VM_STREAM;
`endif

   assign s_ready = en && !rst && active && (mode_eff == VM_STREAM);

   // Raster counters; held at the origin while stopped.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   // Pixel source select; a missing stream pixel is dropped, not waited for.
   always_comb begin
      pix_d = RGB_BLACK;
      uf_d  = 1'b0;
      if (active) begin
         if (mode_eff == VM_STREAM) begin
            if (s_valid) pix_d = rgb24'(s_data);
            else         uf_d  = 1'b1;
         end
`ifdef VTG_PATTERN_EN
         else begin
            pix_d = pat_pix;
         end
`endif
      end
   end

   // Registered outputs, all one cycle behind the counters.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         de        <= 1'b0;
         hs        <= ~HS_POL;
         vs        <= ~VS_POL;
         r         <= '0;
         g         <= '0;
         b         <= '0;
         x         <= '0;
         y         <= '0;
         sof       <= 1'b0;
         sol       <= 1'b0;
         underflow <= 1'b0;
      end else begin
         de        <= active;
         hs        <= hs_on ? HS_POL : ~HS_POL;
         vs        <= vs_on ? VS_POL : ~VS_POL;
         r         <= pix_d.r;
         g         <= pix_d.g;
         b         <= pix_d.b;
         x         <= h_cnt;
         y         <= v_cnt;
         sof       <= active && origin;
         sol       <= active && (h_cnt == '0);
         underflow <= uf_d;
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a 14x7 raster.
// A reference raster model feeds a scoreboard compared each cycle.
module tb_video_timing_gen;

   localparam int H_RES  = 8;
   localparam int H_FP   = 2;
   localparam int H_SYNC = 2;
   localparam int H_BP   = 2;
   localparam int V_RES  = 4;
   localparam int V_FP   = 1;
   localparam int V_SYNC = 1;
   localparam int V_BP   = 1;
   localparam int H_TOT  = H_RES + H_FP + H_SYNC + H_BP;
   localparam int V_TOT  = V_RES + V_FP + V_SYNC + V_BP;
   localparam int CHK    = 1;
`ifdef VTG_PATTERN_EN
   localparam int ACC_BAR = 32;
`else
   localparam int ACC_BAR = 64;
`endif

   typedef struct packed {
      logic        de;
      logic        hs;
      logic        vs;
      logic        hs2;
      logic        vs2;
      logic [23:0] rgb;
      logic [11:0] x;
      logic [11:0] y;
      logic        sof;
      logic        sol;
      logic        uf;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [1:0]  mode;
   logic        s_valid;
   logic [23:0] s_data;
   logic        s_ready, de, hs, vs, sof, sol, underflow;
   logic [7:0]  r, g, b;
   logic [11:0] x, y;
   logic        p_s_ready, p_de, p_hs, p_vs, p_sof, p_sol, p_uf;
   logic [7:0]  p_r, p_g, p_b;
   logic [11:0] p_x, p_y;

   int n_chk = 0;
   int n_err = 0;
   int mh = 0, mv = 0, mq = 0;
   logic [7:0]  mfc = '0;
   logic [23:0] dat = '0;
   int n_de, n_sof, n_sol, n_uf, n_acc, n_hsl, n_vsl;
   obs_t sbq[$];
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
                             24'h00FF00, 24'hFF00FF, 24'hFF0000,
                             24'h0000FF, 24'h000000};

   always #5 clk = ~clk;

   video_timing_gen #(
      .H_RES(H_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_RES(V_RES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12), .CHK_LOG2(CHK)
   ) u_dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .de(de), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
      .x(x), .y(y), .sof(sof), .sol(sol), .underflow(underflow)
   );

   video_timing_gen #(
      .H_RES(H_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_RES(V_RES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(12), .CHK_LOG2(CHK)
   ) u_dut_p (
      .clk(clk), .rst(rst), .en(en), .mode(mode),
      .s_valid(s_valid), .s_data(s_data), .s_ready(p_s_ready),
      .de(p_de), .hs(p_hs), .vs(p_vs), .r(p_r), .g(p_g), .b(p_b),
      .x(p_x), .y(p_y), .sof(p_sof), .sol(p_sol), .underflow(p_uf)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      n_de = 0; n_sof = 0; n_sol = 0; n_uf = 0;
      n_acc = 0; n_hsl = 0; n_vsl = 0;
   endtask

   // One clock: model expectation pushed, DUT result popped after the edge.
   task automatic step();
      obs_t e, o;
      logic org, act, hsy, vsy, rdy;
      int meff;
      logic [7:0] fn;
      s_data = dat;
      e = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      rdy = 1'b0;
      if (!rst && en) begin
         org = (mh == 0) && (mv == 0);
         act = (mh < H_RES) && (mv < V_RES);
`ifdef VTG_PATTERN_EN
         meff = org ? int'(mode) : mq;
`else
         meff = 0;
`endif
         fn  = org ? mfc + 8'd1 : mfc;
         hsy = (mh >= H_RES + H_FP) && (mh < H_RES + H_FP + H_SYNC);
         vsy = (mv >= V_RES + V_FP) && (mv < V_RES + V_FP + V_SYNC);
         e.de  = act;
         e.hs  = !hsy;
         e.vs  = !vsy;
         e.hs2 = hsy;
         e.vs2 = vsy;
         e.x   = 12'(mh);
         e.y   = 12'(mv);
         e.sof = act && org;
         e.sol = act && (mh == 0);
         if (act) begin
            case (meff)
               0: begin
                  rdy = 1'b1;
                  if (s_valid) e.rgb = s_data;
                  else         e.uf  = 1'b1;
               end
               1: e.rgb = bars[mh];
               2: e.rgb = {8'(mh), 8'(mv), fn};
               default: e.rgb = (((mh >> CHK) ^ (mv >> CHK)) & 1) != 0 ?
                                24'hFFFFFF : 24'h000000;
            endcase
         end
         if (org) mq = meff;
         mfc = fn;
         if (mh == H_TOT - 1) begin
            mh = 0;
            mv = (mv == V_TOT - 1) ? 0 : mv + 1;
         end else begin
            mh++;
         end
      end else begin
         mh = 0;
         mv = 0;
         if (rst) begin
            mq  = 0;
            mfc = '0;
         end
      end
      sbq.push_back(e);
      #1;
      chk("rdy", 64'({s_ready, p_s_ready}), 64'({rdy, rdy}));
      if (s_valid && s_ready) n_acc++;
      if (s_valid && rdy) dat = dat + 24'd1;
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      o = {de, hs, vs, p_hs, p_vs, r, g, b, x, y, sof, sol, underflow};
      if (!e.de) begin
         e.x = '0; e.y = '0; o.x = '0; o.y = '0;
      end
      chk("pix", 64'(o), 64'(e));
      n_de  += int'(de);
      n_sof += int'(sof);
      n_sol += int'(sol);
      n_uf  += int'(underflow);
      n_hsl += int'(!hs);
      n_vsl += int'(!vs);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_to(input int hh, input int vv);
      int k;
      k = 0;
      while (!(mh == hh && mv == vv) && k < 200) begin
         step();
         k++;
      end
      if (k >= 200) chk("bound", 64'd0, 64'd1);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; mode = 2'd0;
      s_valid = 1'b1; s_data = '0;
      run(5);
      chk("rst_de", 64'({de, sof, sol, underflow}), 64'd0);
      chk("rst_sync", 64'({hs, vs, p_hs, p_vs}), 64'b1100);
      chk("rst_px", 64'({r, g, b, x, y}), 64'd0);

      rst = 1'b0;
      clr();
      run(2 * H_TOT * V_TOT);
      chk("t1_de", 64'(n_de), 64'd64);
      chk("t1_sof", 64'(n_sof), 64'd2);
      chk("t1_sol", 64'(n_sol), 64'd8);
      chk("t1_hsl", 64'(n_hsl), 64'd28);
      chk("t1_vsl", 64'(n_vsl), 64'd28);
      chk("t2_acc", 64'(n_acc), 64'd64);
      chk("t1_uf", 64'(n_uf), 64'd0);

      clr();
      for (int i = 0; i < H_TOT * V_TOT; i++) begin
         s_valid = !(mv == 1 && (mh == 3 || mh == 4));
         step();
      end
      s_valid = 1'b1;
      chk("t3_uf", 64'(n_uf), 64'd2);
      chk("t3_acc", 64'(n_acc), 64'd30);
      chk("t3_de", 64'(n_de), 64'd32);

      clr();
      run_to(0, 1);
      mode = 2'd1;
      run_to(0, 0);
      run(H_TOT * V_TOT);
      chk("t4_acc", 64'(n_acc), 64'(ACC_BAR));
      mode = 2'd2;
      run(2 * H_TOT * V_TOT);
      mode = 2'd3;
      run(H_TOT * V_TOT);
      mode = 2'd0;
      run(H_TOT * V_TOT);

      run_to(5, 2);
      en = 1'b0;
      clr();
      run(3);
      chk("t5_idle", 64'(n_de + n_sol + n_sof), 64'd0);
      en = 1'b1;
      step();
      chk("t5_sof", 64'({sof, x, y}), 64'({1'b1, 24'd0}));
      run(H_TOT * V_TOT);

      run_to(3, 1);
      rst = 1'b1;
      step();
      chk("t6_rst", 64'({de, hs, p_hs, x}), 64'({3'b010, 12'd0}));
      rst = 1'b0;
      step();
      chk("t6_sof", 64'(sof), 64'd1);
      run(H_TOT * V_TOT);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
